mc_ctl: RTL and testbench
=========================

MC_CTL -- requirements
Module: mc_ctl

Interface
REQ-001 The block SHALL have parameter ALUOP_W, default 5, meaning ALUOp width (>=5; bits above [4] driven 0).
REQ-002 The block SHALL have parameter TIMEOUT, default 15, meaning maximum cycles to wait for mem_ready (0 disables the timeout).
REQ-003 The block SHALL have the port clk, input, 1 bit, meaning the rising-edge clock.
REQ-004 The block SHALL have the port reset, input, 1 bit, meaning reset; the reset is synchronous and active-high.
REQ-005 The block SHALL have the ports opCode and funct, input, 6 bits each, meaning the instruction fields from the instruction register.
REQ-006 The block SHALL have the port mem_ready, input, 1 bit, meaning memory completes the current access this cycle.
REQ-007 The block SHALL have the port zero, input, 1 bit, meaning ALU result equals zero.
REQ-008 The block SHALL have the single-bit outputs IRWrite, PCWrite, IorD, MemRead, MemWrite, MemToReg, RegWrite, ALUSrcA and Exception.
REQ-009 The block SHALL have the 2-bit outputs PCSrc, RegDst, ALUSrcB and Cause.
REQ-010 The block SHALL have the outputs ALUOp[ALUOP_W-1:0] and state[3:0], where state is the current FSM state.

Function
REQ-011 The block SHALL be a Moore FSM with 4-bit state register: FETCH=0, DECODE=1, MEMADDR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, IEXEC=8, IWB=9, BRANCH=10, JUMP=11, EXC=12; codes 13-15 SHALL go to FETCH.
REQ-012 The block SHALL drive every output not listed for the current state as 0; ALUOp encodings: add 00000, sub 00001, and 11000, or 11110, xor 10110, nor 10001, slt 00111, sll 01000, srl 01001, sra 01011.
REQ-013 In FETCH the block SHALL assert MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add; IRWrite and PCWrite SHALL assert only in the cycle mem_ready=1, and the next state SHALL then be DECODE, otherwise FETCH.
REQ-014 In DECODE the block SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=add, latch opCode/funct into internal registers, and branch: lw(100011)/sw(101011)->MEMADDR; R-type funct add/sub/and/or/xor/nor/slt/sll/srl/sra->EXEC; addi/andi/ori/xori->IEXEC; beq/bne->BRANCH; j/jal/jr(funct 001000)->JUMP; anything else->EXC with Cause=01.
REQ-015 In MEMADDR the block SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=add; next MEMRD for latched lw, MEMWR for sw.
REQ-016 In MEMRD the block SHALL drive MemRead=1, IorD=1; on mem_ready next SHALL be MEMWB. MEMWB SHALL assert RegWrite, MemToReg, RegDst=01, then FETCH.
REQ-017 In MEMWR the block SHALL drive MemWrite=1, IorD=1; on mem_ready next SHALL be FETCH.
REQ-018 In EXEC the block SHALL drive ALUSrcA=1, ALUSrcB=01 for sll/srl/sra else 00, ALUOp from latched funct; next RWB; RWB SHALL assert RegWrite, RegDst=00, then FETCH.
REQ-019 In IEXEC the block SHALL drive ALUSrcA=1, ALUSrcB=11 for addi else 10, ALUOp add/and/or/xor per opcode; next IWB; IWB SHALL assert RegWrite, RegDst=01, then FETCH.
REQ-020 In BRANCH the block SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCSrc=01, PCWrite=(beq&zero)|(bne&~zero); next FETCH.
REQ-021 In JUMP the block SHALL assert PCWrite with PCSrc=10 for j/jal, 11 for jr; for jal additionally RegWrite with RegDst=10; next FETCH.
REQ-022 The block SHALL keep a wait counter cleared on every state change and incremented each FETCH/MEMRD/MEMWR cycle with mem_ready=0; when TIMEOUT>0 and the counter reaches TIMEOUT-1 with mem_ready still 0, next state SHALL be EXC with Cause=10 (FETCH) or 11 (MEMRD/MEMWR); mem_ready=1 in that same cycle SHALL win.
REQ-023 EXC SHALL last exactly one cycle, assert Exception with the registered Cause, assert no write strobe, then go to FETCH; Cause SHALL hold until the next EXC entry.
REQ-024 Total latency: R-type/immediate 4 cycles, lw 5, sw 4, branch/jump 3, each plus memory wait cycles.

Reset
REQ-025 On a clock edge with reset=1 the block SHALL set state=FETCH, wait counter=0, latched fields=0, Cause=00, aborting any operation in progress.
REQ-026 While reset=1 every output except state SHALL be driven 0 regardless of state.

Verification
REQ-027 reset 2 cycles, mem_ready=1, opCode=000000 funct=100000 -> states 0,1,6,7,0; RegWrite=1 RegDst=00 only in RWB; ALUOp=00000.
REQ-028 lw with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, MemRead=1 IorD=1 throughout, then MEMWB with MemToReg=1 RegDst=01.
REQ-029 beq zero=1 -> PCWrite=1 PCSrc=01 in BRANCH; bne zero=1 -> PCWrite=0.
REQ-030 opCode=111111 -> DECODE then EXC, Exception=1 one cycle, Cause=01, then FETCH.
REQ-031 TIMEOUT=4, mem_ready=0 in FETCH -> EXC after 4 FETCH cycles, Cause=10; repeat with mem_ready=1 on 4th cycle -> DECODE, no exception.
REQ-032 reset asserted during MEMWR -> next cycle state=0, MemWrite=0, Cause=00.

Source files
------------

// File: rtl/mc_ctl.sv
// rtl/mc_ctl.sv - multicycle processor control FSM with memory-wait timeout and exception cause
module mc_ctl #(
  parameter int ALUOP_W = 5,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opCode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  input  logic               zero,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemToReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic               Exception,
  output logic [1:0]         PCSrc,
  output logic [1:0]         RegDst,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         Cause,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_IEXEC   = 4'd8,
    S_IWB     = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_EXC     = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b11000;
  localparam logic [4:0] ALU_OR  = 5'b11110;
  localparam logic [4:0] ALU_XOR = 5'b10110;
  localparam logic [4:0] ALU_NOR = 5'b10001;
  localparam logic [4:0] ALU_SLT = 5'b00111;
  localparam logic [4:0] ALU_SLL = 5'b01000;
  localparam logic [4:0] ALU_SRL = 5'b01001;
  localparam logic [4:0] ALU_SRA = 5'b01011;

  localparam int CNT_W = $clog2(TIMEOUT + 2);

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       op_q;
  logic [5:0]       fn_q;
  logic [1:0]       cause_q;
  logic             timeout_hit;
  logic [4:0]       alu5;

  // Supported R-type functions; anything else decodes as illegal.
  function automatic logic is_r_alu(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
      6'b100111, 6'b101010, 6'b000000, 6'b000010, 6'b000011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] r_aluop(input logic [5:0] f);
    case (f)
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b100110: return ALU_XOR;
      6'b100111: return ALU_NOR;
      6'b101010: return ALU_SLT;
      6'b000000: return ALU_SLL;
      6'b000010: return ALU_SRL;
      6'b000011: return ALU_SRA;
      default:   return ALU_ADD;
    endcase
  endfunction

  function automatic logic is_shift(input logic [5:0] f);
    return (f == 6'b000000) || (f == 6'b000010) || (f == 6'b000011);
  endfunction

  assign timeout_hit = (TIMEOUT > 0) && (cnt == CNT_W'(TIMEOUT - 1));
  assign state       = st;

  // Counter defaults to clear; only a wait state that stays put increments it.
  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= S_FETCH;
      cnt     <= '0;
      op_q    <= '0;
      fn_q    <= '0;
      cause_q <= 2'b00;
    end else begin
      cnt <= '0;
      case (st)
        S_FETCH: begin
          if (mem_ready) begin
            st <= S_DECODE;
          end else if (timeout_hit) begin
            st      <= S_EXC;
            cause_q <= 2'b10;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DECODE: begin
          op_q <= opCode;
          fn_q <= funct;
          if (opCode == OP_LW || opCode == OP_SW) begin
            st <= S_MEMADDR;
          end else if (opCode == OP_R && is_r_alu(funct)) begin
            st <= S_EXEC;
          end else if (opCode == OP_R && funct == FN_JR) begin
            st <= S_JUMP;
          end else if (opCode == OP_ADDI || opCode == OP_ANDI ||
                       opCode == OP_ORI  || opCode == OP_XORI) begin
            st <= S_IEXEC;
          end else if (opCode == OP_BEQ || opCode == OP_BNE) begin
            st <= S_BRANCH;
          end else if (opCode == OP_J || opCode == OP_JAL) begin
            st <= S_JUMP;
          end else begin
            st      <= S_EXC;
            cause_q <= 2'b01;
          end
        end
        S_MEMADDR: st <= (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD: begin
          if (mem_ready) begin
            st <= S_MEMWB;
          end else if (timeout_hit) begin
            st      <= S_EXC;
            cause_q <= 2'b11;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_MEMWR: begin
          if (mem_ready) begin
            st <= S_FETCH;
          end else if (timeout_hit) begin
            st      <= S_EXC;
            cause_q <= 2'b11;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_EXEC:  st <= S_RWB;
        S_IEXEC: st <= S_IWB;
        default: st <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemToReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    Exception = 1'b0;
    PCSrc     = 2'b00;
    RegDst    = 2'b00;
    ALUSrcB   = 2'b00;
    Cause     = 2'b00;
    alu5      = ALU_ADD;
    if (!reset) begin
      Cause = cause_q;
      case (st)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: ALUSrcB = 2'b11;
        S_MEMADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
          RegDst   = 2'b01;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = is_shift(fn_q) ? 2'b01 : 2'b00;
          alu5    = r_aluop(fn_q);
        end
        S_RWB: RegWrite = 1'b1;
        S_IEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = (op_q == OP_ADDI) ? 2'b11 : 2'b10;
          case (op_q)
            OP_ANDI: alu5 = ALU_AND;
            OP_ORI:  alu5 = ALU_OR;
            OP_XORI: alu5 = ALU_XOR;
            default: alu5 = ALU_ADD;
          endcase
        end
        S_IWB: begin
          RegWrite = 1'b1;
          RegDst   = 2'b01;
        end
        S_BRANCH: begin
          ALUSrcA = 1'b1;
          alu5    = ALU_SUB;
          PCSrc   = 2'b01;
          PCWrite = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
        end
        S_JUMP: begin
          PCWrite = 1'b1;
          PCSrc   = (op_q == OP_R) ? 2'b11 : 2'b10;
          if (op_q == OP_JAL) begin
            RegWrite = 1'b1;
            RegDst   = 2'b10;
          end
        end
        S_EXC: Exception = 1'b1;
        default: ;
      endcase
    end
    ALUOp      = '0;
    ALUOp[4:0] = alu5;
  end

endmodule

// File: tb/tb_mc_ctl.sv
// tb/tb_mc_ctl.sv - scoreboard bench for mc_ctl, one task per scenario
module tb_mc_ctl;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_XORI = 6'b001110;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BAD = 6'b111111, FN_ADD = 6'b100000, FN_JR = 6'b001000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opCode = '0;
  logic [5:0] funct = '0;
  logic       mem_ready = 1'b0;
  logic       zero = 1'b0;
  logic       IRWrite, PCWrite, IorD, MemRead, MemWrite, MemToReg, RegWrite, ALUSrcA, Exception;
  logic [1:0] PCSrc, RegDst, ALUSrcB, Cause;
  logic [4:0] ALUOp;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0] st;
    logic irw, pcw, iord, mrd, mwr, m2r, rw, asa, exc;
    logic [1:0] pcsrc, regdst, asb, cause;
    logic [4:0] alu;
  } ov_t;

  typedef struct packed {
    logic rst; logic [5:0] op; logic [5:0] fn; logic mr; logic z;
  } stim_t;

  typedef struct packed { stim_t s; ov_t e; } plan_t;

  plan_t plan[$];
  ov_t   sb[$];
  int    n_run = 0;
  int    n_fail = 0;

  mc_ctl #(.ALUOP_W(5), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opCode(opCode), .funct(funct),
    .mem_ready(mem_ready), .zero(zero),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .Exception(Exception), .PCSrc(PCSrc), .RegDst(RegDst),
    .ALUSrcB(ALUSrcB), .Cause(Cause), .ALUOp(ALUOp), .state(state)
  );

  always #5 clk = ~clk;

  function automatic ov_t mk(input logic [3:0] st, input logic irw, pcw, iord, mrd, mwr, m2r, rw, asa, exc,
                             input logic [1:0] pcsrc, regdst, asb, cause, input logic [4:0] alu);
    return {st, irw, pcw, iord, mrd, mwr, m2r, rw, asa, exc, pcsrc, regdst, asb, cause, alu};
  endfunction

  function automatic ov_t fe(input logic r, input logic [1:0] c);
    return mk(0, r, r, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, c, 5'd0);
  endfunction
  function automatic ov_t de(input logic [1:0] c);
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd3, c, 5'd0);
  endfunction
  function automatic ov_t ma(input logic [1:0] c);
    return mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd2, c, 5'd0);
  endfunction
  function automatic ov_t mrd(input logic [1:0] c);
    return mk(3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, c, 5'd0);
  endfunction
  function automatic ov_t exc(input logic [1:0] c);
    return mk(12, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, c, 5'd0);
  endfunction

  function automatic ov_t obs();
    return {state, IRWrite, PCWrite, IorD, MemRead, MemWrite, MemToReg, RegWrite, ALUSrcA, Exception,
            PCSrc, RegDst, ALUSrcB, Cause, ALUOp};
  endfunction

  task automatic add(input logic rst, input logic [5:0] op, fn, input logic mr, z, input ov_t e);
    plan_t p;
    p.s = '{rst: rst, op: op, fn: fn, mr: mr, z: z};
    p.e = e;
    plan.push_back(p);
  endtask

  task automatic apply(input stim_t s);
    reset = s.rst; opCode = s.op; funct = s.fn; mem_ready = s.mr; zero = s.z;
  endtask

  task automatic test_reset();
    plan_t p; ov_t e; ov_t o; int k = 0;
    add(1, OP_R, FN_ADD, 1, 0, '0);
    add(1, OP_BAD, FN_JR, 1, 1, '0);
    while (plan.size() > 0) begin
      p = plan.pop_front(); @(posedge clk); #1; apply(p.s); sb.push_back(p.e);
      @(negedge clk); e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL reset cyc%0d: got %h want %h", k, o, e); end
      k++;
    end
  endtask

  task automatic test_rtype();
    plan_t p; ov_t e; ov_t o; int k = 0;
    logic [5:0] fns [6] = '{6'b100000, 6'b100010, 6'b100111, 6'b101010, 6'b000000, 6'b000011};
    logic [4:0] alus [6] = '{5'b00000, 5'b00001, 5'b10001, 5'b00111, 5'b01000, 5'b01011};
    logic [1:0] asbs [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    for (int i = 0; i < 6; i++) begin
      add(0, OP_R, fns[i], 1, 0, fe(1, 0));
      add(0, OP_R, fns[i], 1, 0, de(0));
      add(0, OP_R, fns[i], 1, 0, mk(6, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, asbs[i], 2'd0, alus[i]));
      add(0, OP_R, fns[i], 1, 0, mk(7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0));
    end
    while (plan.size() > 0) begin
      p = plan.pop_front(); @(posedge clk); #1; apply(p.s); sb.push_back(p.e);
      @(negedge clk); e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL rtype cyc%0d: got %h want %h", k, o, e); end
      k++;
    end
  endtask

  task automatic test_mem();
    plan_t p; ov_t e; ov_t o; int k = 0;
    add(0, OP_LW, 0, 1, 0, fe(1, 0));
    add(0, OP_LW, 0, 1, 0, de(0));
    add(0, OP_LW, 0, 1, 0, ma(0));
    for (int i = 0; i < 3; i++) add(0, OP_LW, 0, 0, 0, mrd(0));
    add(0, OP_LW, 0, 1, 0, mrd(0));
    add(0, OP_LW, 0, 1, 0, mk(4, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'd0, 2'd1, 2'd0, 2'd0, 5'd0));
    add(0, OP_SW, 0, 1, 0, fe(1, 0));
    add(0, OP_SW, 0, 1, 0, de(0));
    add(0, OP_SW, 0, 1, 0, ma(0));
    add(0, OP_SW, 0, 0, 0, mk(5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0));
    add(0, OP_SW, 0, 1, 0, mk(5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0));
    while (plan.size() > 0) begin
      p = plan.pop_front(); @(posedge clk); #1; apply(p.s); sb.push_back(p.e);
      @(negedge clk); e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL mem cyc%0d: got %h want %h", k, o, e); end
      k++;
    end
  endtask

  task automatic test_imm();
    plan_t p; ov_t e; ov_t o; int k = 0;
    logic [5:0] ops [4] = '{OP_ADDI, OP_ANDI, OP_ORI, OP_XORI};
    logic [4:0] alus [4] = '{5'b00000, 5'b11000, 5'b11110, 5'b10110};
    logic [1:0] asbs [4] = '{2'd3, 2'd2, 2'd2, 2'd2};
    for (int i = 0; i < 4; i++) begin
      add(0, ops[i], 6'h2a, 1, 0, fe(1, 0));
      add(0, ops[i], 6'h2a, 1, 0, de(0));
      add(0, ops[i], 6'h2a, 1, 0, mk(8, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, asbs[i], 2'd0, alus[i]));
      add(0, ops[i], 6'h2a, 1, 0, mk(9, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd1, 2'd0, 2'd0, 5'd0));
    end
    while (plan.size() > 0) begin
      p = plan.pop_front(); @(posedge clk); #1; apply(p.s); sb.push_back(p.e);
      @(negedge clk); e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL imm cyc%0d: got %h want %h", k, o, e); end
      k++;
    end
  endtask

  task automatic test_branch_jump();
    plan_t p; ov_t e; ov_t o; int k = 0;
    logic [5:0] bops [4] = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
    logic       bz   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       bpcw [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [5:0] jops [3] = '{OP_J, OP_JAL, OP_R};
    logic [5:0] jfns [3] = '{6'd0, 6'd0, FN_JR};
    logic [1:0] jsrc [3] = '{2'd2, 2'd2, 2'd3};
    logic       jrw  [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0] jdst [3] = '{2'd0, 2'd2, 2'd0};
    for (int i = 0; i < 4; i++) begin
      add(0, bops[i], 0, 1, bz[i], fe(1, 0));
      add(0, bops[i], 0, 1, bz[i], de(0));
      add(0, bops[i], 0, 1, bz[i], mk(10, 0, bpcw[i], 0, 0, 0, 0, 0, 1, 0, 2'd1, 2'd0, 2'd0, 2'd0, 5'd1));
    end
    for (int i = 0; i < 3; i++) begin
      add(0, jops[i], jfns[i], 1, 0, fe(1, 0));
      add(0, jops[i], jfns[i], 1, 0, de(0));
      add(0, jops[i], jfns[i], 1, 0, mk(11, 0, 1, 0, 0, 0, 0, jrw[i], 0, 0, jsrc[i], jdst[i], 2'd0, 2'd0, 5'd0));
    end
    while (plan.size() > 0) begin
      p = plan.pop_front(); @(posedge clk); #1; apply(p.s); sb.push_back(p.e);
      @(negedge clk); e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL brjmp cyc%0d: got %h want %h", k, o, e); end
      k++;
    end
  endtask

  task automatic test_illegal();
    plan_t p; ov_t e; ov_t o; int k = 0;
    add(0, OP_BAD, FN_JR, 1, 0, fe(1, 0));
    add(0, OP_BAD, FN_JR, 1, 0, de(0));
    add(0, OP_BAD, FN_JR, 1, 0, exc(1));
    add(0, OP_R, 6'b111111, 1, 0, fe(1, 1));
    add(0, OP_R, 6'b111111, 1, 0, de(1));
    add(0, OP_R, 6'b111111, 1, 0, exc(1));
    while (plan.size() > 0) begin
      p = plan.pop_front(); @(posedge clk); #1; apply(p.s); sb.push_back(p.e);
      @(negedge clk); e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL illegal cyc%0d: got %h want %h", k, o, e); end
      k++;
    end
  endtask

  task automatic test_timeout();
    plan_t p; ov_t e; ov_t o; int k = 0;
    for (int i = 0; i < 4; i++) add(0, OP_R, FN_ADD, 0, 0, fe(0, 1));
    add(0, OP_R, FN_ADD, 0, 0, exc(2));
    for (int i = 0; i < 3; i++) add(0, OP_R, FN_ADD, 0, 0, fe(0, 2));
    add(0, OP_R, FN_ADD, 1, 0, fe(1, 2));
    add(0, OP_R, FN_ADD, 1, 0, de(2));
    add(0, OP_R, FN_ADD, 1, 0, mk(6, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd2, 5'd0));
    add(0, OP_R, FN_ADD, 1, 0, mk(7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd2, 5'd0));
    add(0, OP_LW, 0, 1, 0, fe(1, 2));
    add(0, OP_LW, 0, 1, 0, de(2));
    add(0, OP_LW, 0, 1, 0, ma(2));
    for (int i = 0; i < 4; i++) add(0, OP_LW, 0, 0, 0, mrd(2));
    add(0, OP_LW, 0, 0, 0, exc(3));
    while (plan.size() > 0) begin
      p = plan.pop_front(); @(posedge clk); #1; apply(p.s); sb.push_back(p.e);
      @(negedge clk); e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL timeout cyc%0d: got %h want %h", k, o, e); end
      k++;
    end
  endtask

  task automatic test_reset_mid();
    plan_t p; ov_t e; ov_t o; int k = 0;
    add(0, OP_SW, 0, 1, 0, fe(1, 3));
    add(0, OP_SW, 0, 1, 0, de(3));
    add(0, OP_SW, 0, 1, 0, ma(3));
    add(1, OP_SW, 0, 0, 0, mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0));
    add(0, OP_SW, 0, 0, 0, fe(0, 0));
    while (plan.size() > 0) begin
      p = plan.pop_front(); @(posedge clk); #1; apply(p.s); sb.push_back(p.e);
      @(negedge clk); e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL reset_mid cyc%0d: got %h want %h", k, o, e); end
      k++;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_rtype();
    test_mem();
    test_imm();
    test_branch_jump();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
